// File: rtl/shift_sched.sv
// rtl/shift_sched.sv - round-robin scheduler sharing one 32-bit shifter between two requesters
// ROL is built from a left pass and a complementary right pass whose results are ORed.
module shift_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_data,
    input  logic [4:0]  req0_n,
    input  logic [1:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_data,
    input  logic [4:0]  req1_n,
    input  logic [1:0]  req1_op,
    output logic [31:0] sh_in,
    output logic [4:0]  sh_n,
    output logic        sh_dir,
    output logic        sh_arith,
    input  logic [31:0] sh_out,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_src,
    output logic        busy
);
    localparam logic [1:0] OP_ROL = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;

    state_t      state;
    state_t      state_nx;
    logic        last_grant;
    logic        grant;
    logic        accept;
    logic        src_r;
    logic [31:0] data_r;
    logic [31:0] acc;
    logic [4:0]  n_r;
    logic [1:0]  op_r;

    // With both or neither port valid, the port not served last gets the grant.
    always_comb begin
        grant = ~last_grant;
        if (req0_valid && !req1_valid)
            grant = 1'b0;
        else if (req1_valid && !req0_valid)
            grant = 1'b1;
    end

    assign req0_ready = (state == IDLE) && !grant;
    assign req1_ready = (state == IDLE) && grant;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = PASS1;
            PASS1:   state_nx = (op_r == OP_ROL && n_r != 5'd0) ? PASS2 : RESP;
            PASS2:   state_nx = RESP;
            RESP:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sh_in      = 32'd0;
        sh_n       = 5'd0;
        sh_dir     = 1'b0;
        sh_arith   = 1'b0;
        resp_valid = 1'b0;
        resp_data  = 32'd0;
        resp_src   = 1'b0;
        busy       = (state != IDLE);
        case (state)
            PASS1: begin
                sh_in    = data_r;
                sh_n     = n_r;
                sh_dir   = op_r[0];
                sh_arith = (op_r == OP_SRA);
            end
            PASS2: begin
                // 32-n modulo 32: the right-shift half of the rotate
                sh_in  = data_r;
                sh_n   = 5'd0 - n_r;
                sh_dir = 1'b1;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_data  = acc;
                resp_src   = src_r;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            src_r      <= 1'b0;
            data_r     <= 32'd0;
            n_r        <= 5'd0;
            op_r       <= 2'b00;
            acc        <= 32'd0;
        end else begin
            if (accept) begin
                last_grant <= grant;
                src_r      <= grant;
                data_r     <= grant ? req1_data : req0_data;
                n_r        <= grant ? req1_n : req0_n;
                op_r       <= grant ? req1_op : req0_op;
            end
            if (state == PASS1)
                acc <= sh_out;
            else if (state == PASS2)
                acc <= acc | sh_out;
        end
    end
endmodule

// File: tb/tb_shift_sched.sv
// tb/tb_shift_sched.sv - scoreboard bench for shift_sched with a behavioural shifter
module tb_shift_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_n, req1_n;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] sh_in, sh_out;
    logic [4:0]  sh_n;
    logic        sh_dir, sh_arith;
    logic        resp_valid, resp_ready, resp_src, busy;
    logic [31:0] resp_data;

    localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b11, ROL = 2'b10;

    typedef struct {
        logic        src;
        logic [31:0] data;
        int          cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    logic grant_log[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    logic prev_rv = 1'b0;

    shift_sched dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_n(req0_n), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_n(req1_n), .req1_op(req1_op),
        .sh_in(sh_in), .sh_n(sh_n), .sh_dir(sh_dir), .sh_arith(sh_arith), .sh_out(sh_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_src(resp_src), .busy(busy)
    );

    assign sh_out = sh_dir ? (sh_arith ? 32'($signed(sh_in) >>> sh_n) : (sh_in >> sh_n))
                           : (sh_in << sh_n);

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] n,
                                          input logic [1:0] op);
        case (op)
            SLL:     return d << n;
            SRL:     return d >> n;
            SRA:     return 32'($signed(d) >>> n);
            default: return (d << n) | (d >> (6'd32 - {1'b0, n}));
        endcase
    endfunction

    function automatic int lat_of(input logic [4:0] n, input logic [1:0] op);
        return (op == ROL && n != 5'd0) ? 3 : 2;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_rv = 1'b0;
        end else begin
            if (req0_valid && req0_ready) begin
                sb.push_back('{1'b0, model(req0_data, req0_n, req0_op), cyc, lat_of(req0_n, req0_op)});
                grant_log.push_back(1'b0);
            end
            if (req1_valid && req1_ready) begin
                sb.push_back('{1'b1, model(req1_data, req1_n, req1_op), cyc, lat_of(req1_n, req1_op)});
                grant_log.push_back(1'b1);
            end
            if (resp_valid && !prev_rv)
                rise_cyc = cyc;
            prev_rv = resp_valid;
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    check("resp_with_empty_sb", 32'(sb.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_data", resp_data, e.data);
                    check("resp_src", 32'(resp_src), 32'(e.src));
                    check("resp_latency", 32'(rise_cyc - e.cyc), 32'(e.lat));
                end
            end
        end
    end

    task automatic send(input logic port, input logic [31:0] d, input logic [4:0] n,
                        input logic [1:0] op);
        int t;
        logic rdy;
        if (port) begin
            req1_data = d; req1_n = n; req1_op = op; req1_valid = 1'b1;
        end else begin
            req0_data = d; req0_n = n; req0_op = op; req0_valid = 1'b1;
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
            rdy = port ? req1_ready : req0_ready;
        end while (!rdy && t < 100);
        if (!rdy)
            check("req_accept_timeout", 32'(rdy), 32'd1);
        @(posedge clk);
        #1;
        if (port) req1_valid = 1'b0;
        else      req0_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((busy || sb.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100)
            check("drain_timeout", 32'(t), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_data = '0; req0_n = '0; req0_op = '0;
        req1_valid = 1'b0; req1_data = '0; req1_n = '0; req1_op = '0;
        resp_ready = 1'b1;
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sh_in", sh_in, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_req0_ready", 32'(req0_ready), 32'd1);
        check("rel_req1_ready", 32'(req1_ready), 32'd0);

        send(1'b0, 32'h0000_0001, 5'd4, SLL);
        drain();
        send(1'b1, 32'h8000_0000, 5'd31, SRA);
        drain();
        send(1'b1, 32'h8000_0000, 5'd31, SRL);
        drain();

        send(1'b0, 32'h8000_0001, 5'd1, ROL);
        @(negedge clk);
        @(negedge clk);
        check("rol_pass2_sh_n", 32'(sh_n), 32'd31);
        check("rol_pass2_dir", 32'(sh_dir), 32'd1);
        check("rol_pass2_arith", 32'(sh_arith), 32'd0);
        check("rol_pass2_sh_in", sh_in, 32'h8000_0001);
        drain();
        send(1'b0, 32'h1234_5678, 5'd0, ROL);
        drain();

        resp_ready = 1'b0;
        send(1'b1, 32'hF0F0_0000, 5'd4, SRL);
        for (int t = 0; t < 10 && !resp_valid; t++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", 32'(resp_valid), 32'd1);
            check("stall_data", resp_data, 32'h0F0F_0000);
            check("stall_src", 32'(resp_src), 32'd1);
            check("stall_readys", {30'd0, req0_ready, req1_ready}, 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        drain();

        send(1'b0, 32'hA5A5_0F0F, 5'd5, ROL);
        @(posedge clk);
        #1;
        check("pre_rst_sh_n", 32'(sh_n), 32'd27);
        check("pre_rst_dir", 32'(sh_dir), 32'd1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_sh_n", 32'(sh_n), 32'd0);
        check("mid_rst_req0_ready", 32'(req0_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("no_stale_resp", 32'(resp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(1'b1, 32'h0000_00FF, 5'd8, SLL);
        drain();

        grant_log.delete();
        fork
            begin
                for (int k = 0; k < 2; k++)
                    send(1'b0, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
            end
            begin
                for (int k = 0; k < 2; k++)
                    send(1'b1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
            end
        join
        drain();
        check("grant_count", 32'(grant_log.size()), 32'd4);
        for (int k = 0; k < grant_log.size() && k < 4; k++)
            check("grant_order", 32'(grant_log[k]), 32'(k % 2));

        for (int k = 0; k < 6; k++) begin
            send(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
                 2'($urandom_range(0, 3)));
            drain();
        end

        check("sb_empty_at_end", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
